key_expansion_ctrl: RTL
=======================

// Module: key_expansion_ctrl
// PURPOSE
//   Sequencer and round-key server for the AES-256 key-expansion datapath.
//   Captures a 256-bit cipher key, resets and enables the expander until it
//   reports ready, then serves 128-bit round keys 0..14 to the cipher core.
//   Sits between the top-level key interface and the expander.
// PARAMETERS
//   NUM_RK      15   number of round keys; valid indices are 0..NUM_RK-1
//   TIMEOUT_CYC 80   maximum EXPAND cycles before the block aborts with err
// PORTS
//   Clk         in   1    clock; all logic on the rising edge
//   Rst         in   1    asynchronous active-low reset
//   start       in   1    pulse: begin expansion of key_in
//   key_in      in   256  cipher key, sampled when start is accepted
//   busy        out  1    high in CLEAR and EXPAND
//   key_valid   out  1    high in DONE: round keys may be read
//   err         out  1    sticky timeout flag; cleared by the next accepted start
//   rk_req      in   1    round-key read request
//   rk_idx      in   4    round-key index
//   rk_ready    out  1    high in DONE when no read is outstanding
//   rk_valid    out  1    one-cycle pulse: rk_data is valid
//   rk_data     out  128  round key; holds its value until the next rk_valid
//   rk_bad      out  1    pulses with rk_valid when rk_idx >= NUM_RK
//   KE_Rst      out  1    expander reset, active-low
//   KE_En       out  1    expander enable
//   KE_data_in  out  256  held key register driven to the expander
//   KE_Addr_Key out  4    expander round-key address, registered
//   KE_ready    in   1    expander done flag
//   KE_Out_Key  in   128  expander round-key output
// BEHAVIOUR
//   Reset values: state=IDLE; busy, key_valid, err, rk_ready, rk_valid, rk_bad,
//     KE_En = 0; KE_Rst = 0; rk_data, KE_data_in, KE_Addr_Key, timeout cnt = 0.
//   FSM (registered outputs):
//   - IDLE: start=1 -> load KE_data_in<=key_in, err<=0, go to CLEAR.
//   - CLEAR: exactly 1 cycle with KE_Rst=0 and KE_En=0; next state EXPAND.
//   - EXPAND: KE_Rst=1, KE_En=1, cnt++ each cycle. KE_ready=1 -> KE_En<=0,
//     go to DONE. cnt==TIMEOUT_CYC-1 without KE_ready -> err<=1, go to IDLE.
//     If both occur in the same cycle, KE_ready wins.
//   - DONE: key_valid=1, KE_En=0. start=1 with no read outstanding -> reload
//     and go to CLEAR (key_valid drops in the next cycle). If a read is
//     outstanding, start is held off: it is accepted in the cycle after
//     rk_valid, provided start is still high.
//   - start in CLEAR or EXPAND is ignored; the key register is stable
//     throughout expansion.
//   Read handshake (DONE only; rk_req in other states is ignored):
//   - Accept on edge E0 when rk_req & rk_ready: KE_Addr_Key<=rk_idx, rk_ready<=0.
//   - Edge E1: rk_data<=KE_Out_Key (0 if bad index), rk_valid<=1, rk_bad as
//     defined. Latency = 2 cycles from request to data; 1 read per 3 cycles.
//   - Edge E2: rk_valid<=0, rk_ready<=1.
//   Counter: $clog2(TIMEOUT_CYC) bits; cleared on entry to EXPAND.
//   Reset mid-operation: all state returns to reset values immediately, and
//     KE_Rst=0 holds the expander in reset.
// CONFIGURATION
//   KEY_REUSE_EN defined: keep a 256-bit copy of the last successfully
//     expanded key plus a valid bit. A start in IDLE or DONE whose key_in
//     equals the copy while the valid bit is set skips CLEAR/EXPAND and goes
//     straight to DONE the next cycle. A timeout or reset clears the valid bit.
//   KEY_REUSE_EN undefined: every start runs a full CLEAR/EXPAND; no copy is
//     kept.
// TESTING
//   1) FIPS-197 AES-256 key 000102..1f, start -> busy=1, then key_valid=1
//      after KE_ready; rk_idx=0 -> 000102..0f, rk_idx=14 -> 24fc79ccbf0979e9371ac23c6d68de36.
//   2) rk_req with rk_idx=15 in DONE -> rk_valid=1, rk_bad=1, rk_data=0.
//   3) Expander model never asserts ready -> err=1 after 80 EXPAND cycles,
//      state IDLE, key_valid=0.
//   4) start asserted the cycle after a read is accepted -> rk_valid occurs
//      first, then CLEAR; KE_Rst low for exactly 1 cycle.
//   5) Rst pulsed low mid-EXPAND -> all outputs return to reset values
//      asynchronously; a new start runs normally.
//   6) KEY_REUSE_EN: the same key started twice -> second start reaches DONE
//      in 1 cycle with no KE_En pulse; a different key runs a full expansion.

Source files
------------

// File: rtl/key_expansion_ctrl.sv
// AES-256 key-expansion sequencer and round-key server in front of the expander.
// Optional feature: define KEY_REUSE_EN to skip re-expansion of an unchanged key.
module key_expansion_ctrl #(
  parameter int NUM_RK      = 15,
  parameter int TIMEOUT_CYC = 80
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         key_valid,
  output logic         err,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic         rk_bad,
  output logic         KE_Rst,
  output logic         KE_En,
  output logic [255:0] KE_data_in,
  output logic [3:0]   KE_Addr_Key,
  input  logic         KE_ready,
  input  logic [127:0] KE_Out_Key
);

  typedef enum logic [1:0] {IDLE, CLEAR, EXPAND, DONE} state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0]        NUM_RK_W = 5'(NUM_RK);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               rd_pend, rd_pend_d;
  logic               busy_d, key_valid_d, err_d, rk_ready_d, rk_valid_d, rk_bad_d;
  logic               ke_rst_d, ke_en_d;
  logic [127:0]       rk_data_d;
  logic [255:0]       ke_data_d;
  logic [3:0]         ke_addr_d;
  logic               accept, timeout, reuse_hit, addr_bad;

  // A start is only taken in IDLE, or in DONE once no read is in flight.
  assign accept   = start && ((state == IDLE) || ((state == DONE) && rk_ready));
  assign timeout  = (state == EXPAND) && !KE_ready && (cnt == CNT_LAST);
  assign addr_bad = {1'b0, KE_Addr_Key} >= NUM_RK_W;

`ifdef KEY_REUSE_EN
  logic [255:0] last_key;
  logic         last_vld;

  assign reuse_hit = last_vld && (key_in == last_key);

  // NOTE: the key copy is an ordinary register, so it is reset like the rest; last_vld alone gates its use.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      last_key <= '0;
      last_vld <= 1'b0;
    end else if ((state == EXPAND) && KE_ready) begin
      last_key <= KE_data_in;
      last_vld <= 1'b1;
    end else if (timeout) begin
      last_vld <= 1'b0;
    end
  end
`else
  assign reuse_hit = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_pend     <= 1'b0;
      busy        <= 1'b0;
      key_valid   <= 1'b0;
      err         <= 1'b0;
      rk_ready    <= 1'b0;
      rk_valid    <= 1'b0;
      rk_bad      <= 1'b0;
      rk_data     <= '0;
      KE_Rst      <= 1'b0;
      KE_En       <= 1'b0;
      KE_data_in  <= '0;
      KE_Addr_Key <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_d;
      cnt         <= cnt_d;
      rd_pend     <= rd_pend_d;
      busy        <= busy_d;
      key_valid   <= key_valid_d;
      err         <= err_d;
      rk_ready    <= rk_ready_d;
      rk_valid    <= rk_valid_d;
      rk_bad      <= rk_bad_d;
      rk_data     <= rk_data_d;
      KE_Rst      <= ke_rst_d;
      KE_En       <= ke_en_d;
      KE_data_in  <= ke_data_d;
      KE_Addr_Key <= ke_addr_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves state_d unassigned (no latch).
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = reuse_hit ? DONE : CLEAR;
      CLEAR:   state_d = EXPAND;
      EXPAND: begin
        if (KE_ready)              state_d = DONE;
        else if (cnt == CNT_LAST)  state_d = IDLE;
      end
      DONE:    if (start && rk_ready) state_d = reuse_hit ? DONE : CLEAR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d      = (state_d == CLEAR) || (state_d == EXPAND);
    key_valid_d = (state_d == DONE);
    ke_en_d     = (state_d == EXPAND);
    ke_rst_d    = KE_Rst;
    if (state_d == CLEAR)       ke_rst_d = 1'b0;
    else if (state_d == EXPAND) ke_rst_d = 1'b1;

    err_d = err;
    if (accept)       err_d = 1'b0;
    else if (timeout) err_d = 1'b1;

    cnt_d     = ((state == EXPAND) && (state_d == EXPAND)) ? cnt + CNT_W'(1) : '0;
    ke_data_d = accept ? key_in : KE_data_in;

    // Read pipeline: accept (E0) -> data (E1) -> ready again (E2).
    ke_addr_d  = KE_Addr_Key;
    rk_data_d  = rk_data;
    rk_ready_d = rk_ready;
    rd_pend_d  = rd_pend;
    rk_valid_d = 1'b0;
    rk_bad_d   = 1'b0;
    if (state_d != DONE) begin
      rk_ready_d = 1'b0;
      rd_pend_d  = 1'b0;
    end else if ((state != DONE) || accept) begin
      rk_ready_d = 1'b1;
    end else if (rd_pend) begin
      rd_pend_d  = 1'b0;
      rk_valid_d = 1'b1;
      rk_bad_d   = addr_bad;
      rk_data_d  = addr_bad ? '0 : KE_Out_Key;
    end else if (rk_valid) begin
      rk_ready_d = 1'b1;
    end else if (rk_req && rk_ready) begin
      ke_addr_d  = rk_idx;
      rk_ready_d = 1'b0;
      rd_pend_d  = 1'b1;
    end
  end

endmodule
